// File: rtl/sam6883.sv
// SAM: E/Q clock generation, CPU address decode (S and Z), control register file at $FFC0-$FFDF,
// and the VDG display address counter.
module sam6883 #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned CLK_DIV = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       a,
  input  logic              rw,
  output logic              e,
  output logic              q,
  output logic [2:0]        s,
  output logic [ADDR_W-1:0] z,
  input  logic              hs_n,
  input  logic              fs_n,
  input  logic              vid_step,
  output logic [ADDR_W-1:0] vaddr,
  output logic              ty
);

  localparam int unsigned PH_W = $clog2(CLK_DIV);
  typedef logic [PH_W-1:0] ph_t;

  localparam ph_t SlowLast = ph_t'(CLK_DIV - 1);
  localparam ph_t SlowQOn  = ph_t'(CLK_DIV / 4);
  localparam ph_t SlowQOff = ph_t'(3 * CLK_DIV / 4);
  localparam ph_t SlowEOn  = ph_t'(CLK_DIV / 2);
  localparam ph_t FastLast = ph_t'(CLK_DIV / 2 - 1);
  localparam ph_t FastQOn  = ph_t'(CLK_DIV / 8);
  localparam ph_t FastQOff = ph_t'(3 * CLK_DIV / 8);
  localparam ph_t FastEOn  = ph_t'(CLK_DIV / 4);

  // Control bits, index 0..15: V[2:0], F[6:0], P1, R[1:0], M[1:0], TY
  logic [15:0] regs;
  logic [2:0]  v;
  logic [6:0]  f;
  logic        p1;
  logic [1:0]  r;
  logic [1:0]  m;

  assign v  = regs[2:0];
  assign f  = regs[9:3];
  assign p1 = regs[10];
  assign r  = regs[12:11];
  assign m  = regs[14:13];
  assign ty = regs[15];

  always_comb begin
    s = 3'd7;
    if (a[15:8] == 8'hFF) begin
      unique case (a[7:5])
        3'd0:    s = 3'd4;
        3'd1:    s = 3'd5;
        3'd2:    s = 3'd6;
        default: s = (a[7:4] == 4'hF) ? 3'd2 : 3'd7;
      endcase
    end else if (ty || !a[15]) begin
      s = 3'd0;
    end else begin
      unique case (a[14:13])
        2'b00:   s = 3'd1;
        2'b01:   s = 3'd2;
        default: s = 3'd3;
      endcase
    end
  end

  logic [15:0] z_full;
  logic [15:0] z_mask;
  logic [15:0] z_masked;

  always_comb begin
    if (a[15:4] == 12'hFFF) begin
      z_full = {4'b1011, a[11:0]};  // vectors fetched from the top of ROM space
    end else if (ty) begin
      z_full = a;
    end else begin
      z_full = {p1, a[14:0]};
    end
    unique case (m)
      2'b00:   z_mask = 16'h0FFF;
      2'b01:   z_mask = 16'h3FFF;
      default: z_mask = 16'hFFFF;
    endcase
  end

  assign z_masked = z_full & z_mask;
  assign z        = z_masked[ADDR_W-1:0];

  // Phase counter; slow selects N = CLK_DIV, else CLK_DIV/2
  ph_t  ph;
  ph_t  ph_nxt;
  ph_t  last_ph;
  ph_t  q_on;
  ph_t  q_off;
  ph_t  e_on;
  logic slow;
  logic cyc_end;
  logic fast_req;
  logic reg_wr;

  assign last_ph  = slow ? SlowLast : FastLast;
  assign q_on     = slow ? SlowQOn  : FastQOn;
  assign q_off    = slow ? SlowQOff : FastQOff;
  assign e_on     = slow ? SlowEOn  : FastEOn;
  assign cyc_end  = (ph == last_ph);
  assign ph_nxt   = cyc_end ? '0 : ph + 1'b1;
  assign fast_req = r[1] | (r[0] & (s == 3'd1 || s == 3'd2 || s == 3'd3));
  assign reg_wr   = cyc_end && !rw && (a[15:5] == 11'h7FE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph   <= '0;
      slow <= 1'b1;
      e    <= 1'b0;
      q    <= 1'b0;
      regs <= '0;
    end else begin
      ph <= ph_nxt;
      e  <= !cyc_end && (ph_nxt >= e_on);
      q  <= !cyc_end && (ph_nxt >= q_on) && (ph_nxt < q_off);
      if (cyc_end) slow <= !fast_req;
      if (reg_wr) regs[a[4:1]] <= a[0];
    end
  end

  // Video address counter
  function automatic logic row16(input logic [2:0] vm);
    return vm[0] && (vm != 3'd7);
  endfunction

  function automatic logic [3:0] last_line(input logic [2:0] vm);
    case (vm)
      3'd0:        return 4'd11;
      3'd1, 3'd2:  return 4'd2;
      3'd3, 3'd4:  return 4'd1;
      default:     return 4'd0;
    endcase
  endfunction

  logic              fs_r;
  logic              hs_r;
  logic              fs_fall;
  logic              hs_fall;
  logic [2:0]        v_act;
  logic [ADDR_W-1:0] row_base;
  logic [4:0]        col;
  logic [4:0]        col_inc;
  logic [4:0]        col_wrap;
  logic [3:0]        line_cnt;
  logic [15:0]       fs_base;
  logic [ADDR_W-1:0] row_step;

  assign fs_base  = {f, 9'b0};
  assign row_step = row16(v) ? ADDR_W'(16) : ADDR_W'(32);
  assign col_inc  = col + 5'd1;
  assign col_wrap = row16(v_act) ? {1'b0, col_inc[3:0]} : col_inc;
  assign vaddr    = row_base + ADDR_W'(col);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fs_r     <= 1'b1;
      hs_r     <= 1'b1;
      fs_fall  <= 1'b0;
      hs_fall  <= 1'b0;
      v_act    <= '0;
      row_base <= '0;
      col      <= '0;
      line_cnt <= '0;
    end else begin
      fs_r    <= fs_n;
      hs_r    <= hs_n;
      fs_fall <= fs_r & ~fs_n;
      hs_fall <= hs_r & ~hs_n;
      if (fs_fall) begin
        row_base <= fs_base[ADDR_W-1:0];
        col      <= '0;
        line_cnt <= '0;
        v_act    <= v;
      end else if (hs_fall) begin
        col   <= '0;
        v_act <= v;
        // >= so a mode switch with a stale larger count still wraps
        if (line_cnt >= last_line(v)) begin
          line_cnt <= '0;
          row_base <= row_base + row_step;
        end else begin
          line_cnt <= line_cnt + 4'd1;
        end
      end else if (vid_step) begin
        col <= col_wrap;
      end
    end
  end

endmodule

// File: tb/tb_sam6883.sv
// Scoreboard bench for sam6883: stimulus queues expected values, a negedge monitor checks them.
module tb_sam6883;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] a = 16'h0000;
  logic        rw = 1'b1;
  logic        e;
  logic        q;
  logic [2:0]  s;
  logic [15:0] z;
  logic        hs_n = 1'b1;
  logic        fs_n = 1'b1;
  logic        vid_step = 1'b0;
  logic [15:0] vaddr;
  logic        ty;

  always #5 clk = ~clk;

  sam6883 #(.ADDR_W(16), .CLK_DIV(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .rw       (rw),
    .e        (e),
    .q        (q),
    .s        (s),
    .z        (z),
    .hs_n     (hs_n),
    .fs_n     (fs_n),
    .vid_step (vid_step),
    .vaddr    (vaddr),
    .ty       (ty)
  );

  typedef enum int {KS, KZ, KE, KQ, KV, KT, KLEN} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] act;
  int          checks = 0;
  int          errors = 0;
  int          len_meas = 0;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      case (cur.kind)
        KS:      act = {29'd0, s};
        KZ:      act = {16'd0, z};
        KE:      act = {31'd0, e};
        KQ:      act = {31'd0, q};
        KV:      act = {16'd0, vaddr};
        KT:      act = {31'd0, ty};
        default: act = len_meas;
      endcase
      checks++;
      if (act !== cur.exp) begin
        errors++;
        $display("FAIL %s: actual %h required %h", cur.name, act, cur.exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_val(input kind_t k, input logic [31:0] v, input string nm);
    exp_t it;
    it.kind = k;
    it.exp  = v;
    it.name = nm;
    sb.push_back(it);
  endtask

  // One CPU cycle: returns at the start of the next cycle (e just fell)
  task automatic bus(input logic [15:0] addr, input logic wr);
    int n = 0;
    a  = addr;
    rw = !wr;
    while (!e && n < 64) begin @(posedge clk); #1; n++; end
    while (e && n < 64) begin @(posedge clk); #1; n++; end
    if (n >= 64) begin
      checks++;
      errors++;
      $display("FAIL bus_timeout: actual %0d clk required < 64", n);
    end
    len_meas = n;
    rw = 1'b1;
  endtask

  task automatic fs_pulse();
    fs_n = 1'b0; tick(1); fs_n = 1'b1; tick(3);
  endtask

  task automatic hs_pulse();
    hs_n = 1'b0; tick(1); hs_n = 1'b1; tick(2);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      vid_step = 1'b1; tick(1); vid_step = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    a = 16'h1234;
    tick(2);
    expect_val(KE, 0, "rst_e");
    expect_val(KQ, 0, "rst_q");
    expect_val(KS, 0, "rst_s");
    expect_val(KZ, 16'h0234, "rst_z");
    expect_val(KV, 0, "rst_vaddr");
    expect_val(KT, 0, "rst_ty");
    sync();
    reset = 1'b1;

    // Slow-cycle phase placement
    tick(4);  expect_val(KQ, 1, "ph4_q");  expect_val(KE, 0, "ph4_e");  sync();
    tick(4);  expect_val(KQ, 1, "ph8_q");  expect_val(KE, 1, "ph8_e");  sync();
    tick(4);  expect_val(KQ, 0, "ph12_q"); expect_val(KE, 1, "ph12_e"); sync();
    tick(4);  expect_val(KQ, 0, "ph0_q");  expect_val(KE, 0, "ph0_e");  sync();

    // Rate select
    bus(16'hFFD7, 1'b1); expect_val(KLEN, 16, "len_write_r0"); sync();
    bus(16'hA000, 1'b0); expect_val(KLEN, 16, "len_a000");     sync();
    bus(16'h0400, 1'b0); expect_val(KLEN, 8,  "len_fast");     sync();
    bus(16'h0400, 1'b0); expect_val(KLEN, 16, "len_slow");     sync();
    bus(16'hFFD6, 1'b1);

    // Map type 0 decode with P1 and no mask
    bus(16'hFFDD, 1'b1);
    bus(16'hFFD5, 1'b1);
    a = 16'h1234; #1;
    expect_val(KS, 0, "s_1234"); expect_val(KZ, 16'h9234, "z_1234"); expect_val(KT, 0, "ty0");
    sync();
    a = 16'hFFFE; #1; expect_val(KS, 2, "s_fffe"); expect_val(KZ, 16'hBFFE, "z_fffe"); sync();
    a = 16'h8000; #1; expect_val(KS, 1, "s_8000"); expect_val(KZ, 16'h8000, "z_8000"); sync();
    a = 16'hA000; #1; expect_val(KS, 2, "s_a000"); sync();
    a = 16'hE000; #1; expect_val(KS, 3, "s_e000"); sync();
    a = 16'hFF00; #1; expect_val(KS, 4, "s_ff00"); sync();
    a = 16'hFF20; #1; expect_val(KS, 5, "s_ff20"); sync();
    a = 16'hFF40; #1; expect_val(KS, 6, "s_ff40"); sync();
    a = 16'hFFC0; #1; expect_val(KS, 7, "s_ffc0"); sync();

    // Map type 1
    bus(16'hFFDF, 1'b1);
    a = 16'hC000; #1;
    expect_val(KT, 1, "ty1"); expect_val(KS, 0, "s_c000_ty1"); expect_val(KZ, 16'hC000, "z_c000_ty1");
    sync();
    a = 16'hFF10; #1; expect_val(KS, 4, "s_ff10_ty1"); sync();
    a = 16'hFFF0; #1; expect_val(KS, 2, "s_fff0_ty1"); expect_val(KZ, 16'hBFF0, "z_fff0_ty1"); sync();

    // Memory size masks
    bus(16'hFFDC, 1'b1);
    a = 16'h3ABC; #1; expect_val(KZ, 16'h0ABC, "z_m00"); sync();
    bus(16'hFFDB, 1'b1);
    a = 16'h3ABC; #1; expect_val(KZ, 16'h3ABC, "z_m01"); sync();
    a = 16'hFABC; #1; expect_val(KZ, 16'h3ABC, "z_m01_hi"); sync();

    // Video counter, V=0, F=2
    bus(16'hFFC9, 1'b1);
    fs_pulse();   expect_val(KV, 16'h0400, "v_fs");     sync();
    step(31);     expect_val(KV, 16'h041F, "v_col31");  sync();
    step(1);      expect_val(KV, 16'h0400, "v_colwrap"); sync();
    for (int i = 0; i < 11; i++) hs_pulse();
    expect_val(KV, 16'h0400, "v_hs11"); sync();
    hs_pulse();   expect_val(KV, 16'h0420, "v_hs12");   sync();
    step(3);      expect_val(KV, 16'h0423, "v_col3");   sync();
    hs_pulse();   expect_val(KV, 16'h0420, "v_hs_colclr"); sync();

    // V=5: 16 bytes, 1 line per row
    bus(16'hFFC1, 1'b1);
    bus(16'hFFC5, 1'b1);
    hs_pulse();   expect_val(KV, 16'h0430, "v5_hs1");   sync();
    hs_pulse();   expect_val(KV, 16'h0440, "v5_hs2");   sync();
    step(17);     expect_val(KV, 16'h0441, "v5_col16wrap"); sync();
    fs_n = 1'b0; hs_n = 1'b0; vid_step = 1'b1;
    tick(1);
    fs_n = 1'b1; hs_n = 1'b1; vid_step = 1'b0;
    tick(3);      expect_val(KV, 16'h0400, "v_priority"); sync();

    // Asynchronous reset while E is high
    begin
      int n = 0;
      while (!e && n < 64) begin tick(1); n++; end
      if (n >= 64) begin
        checks++;
        errors++;
        $display("FAIL wait_e_high: actual e=%0b required 1", e);
      end
    end
    reset = 1'b0;
    #1;
    expect_val(KE, 0, "async_rst_e");
    expect_val(KQ, 0, "async_rst_q");
    expect_val(KV, 0, "async_rst_vaddr");
    expect_val(KT, 0, "async_rst_ty");
    sync();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
